// File: rtl/accel.sv
// accel: single-kernel 2D convolution engine driven by custom host instructions.
//   clk              rising-edge clock
//   rst_ext          asynchronous active-high reset
//   instruction      [6:0] opcode, [11:7] register code, [31:12] immediate
//   mem_in           [35:18] image word, [17:0] filter word (combinational read data)
//   mem_out          [106:86] image addr, [85:70] filter addr, [69:54] output addr,
//                    [53:36] write data, [35] write enable, [34:0] zero
//   accel_done       high while in DONE
//   accel_interrupt  stored interrupt vector while in DONE, else 0
module accel (
    input  logic         clk,
    input  logic         rst_ext,
    input  logic [31:0]  instruction,
    input  logic [35:0]  mem_in,
    output logic [106:0] mem_out,
    output logic         accel_done,
    output logic [18:0]  accel_interrupt
);

    localparam int unsigned IMM_W   = 20;
    localparam int unsigned KW      = 21;
    localparam int unsigned IADDR_W = 21;
    localparam int unsigned FADDR_W = 16;
    localparam int unsigned OADDR_W = 16;
    localparam int unsigned DATA_W  = 18;
    localparam int unsigned PROD_W  = 36;
    localparam int unsigned ACC_W   = 48;
    localparam int unsigned POS_W   = 23;
    localparam int unsigned BUS_W   = 107;
    localparam int unsigned INTR_W  = 19;

    localparam logic [6:0] EXTEND_OPCODE      = 7'b0001011;
    localparam logic [4:0] RD_IMAGE_DIM       = 5'd0;
    localparam logic [4:0] RD_IMAGE_DEPTH     = 5'd1;
    localparam logic [4:0] RD_IMAGE_OFFSET    = 5'd2;
    localparam logic [4:0] RD_FILTER_OFFSET   = 5'd3;
    localparam logic [4:0] RD_OUTPUT_OFFSET   = 5'd4;
    localparam logic [4:0] RD_FILTER_HALFSIZE = 5'd5;
    localparam logic [4:0] RD_FILTER_STRIDE   = 5'd6;
    localparam logic [4:0] RD_FILTER_LENGTH   = 5'd7;
    localparam logic [4:0] RD_FILTER_BIAS     = 5'd8;
    localparam logic [4:0] RD_ACCEL_INTERRUPT = 5'd9;
    localparam logic [4:0] RD_TRIGGER_ACCEL   = 5'd10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // configuration registers
    logic [IMM_W-1:0] dim_q, dim_d, depth_q, depth_d, img_off_q, img_off_d;
    logic [IMM_W-1:0] filt_off_q, filt_off_d, out_off_q, out_off_d, half_q, half_d;
    logic [IMM_W-1:0] stride_q, stride_d, len_q, len_d, bias_q, bias_d, intr_q, intr_d;

    // iteration state: channel, kernel row/col, output window origin, output index
    logic [IMM_W-1:0]   c_q, c_d;
    logic [KW-1:0]      dy_q, dy_d, dx_q, dx_d;
    logic [IADDR_W-1:0] xb_q, xb_d, yb_q, yb_d;
    logic [OADDR_W-1:0] out_idx_q, out_idx_d;
    logic [ACC_W-1:0]   acc_q, acc_d;

    logic [BUS_W-1:0]  mem_out_q, mem_out_d;
    logic              done_q, done_d;
    logic [INTR_W-1:0] intr_out_q, intr_out_d;

    // decode and geometry
    logic [6:0]         opc_c;
    logic [4:0]         code_c;
    logic [IMM_W-1:0]   imm_c;
    logic               is_ext_c, cfg_wr_c;
    logic [KW-1:0]      k_c, k_last_c;
    logic [IMM_W-1:0]   stride_eff_c;
    logic               degenerate_c, last_tap_c, x_fits_c, y_fits_c;
    logic [POS_W-1:0]   xb_nx_c, yb_nx_c;
    logic signed [PROD_W-1:0] prod_c;
    logic [IADDR_W-1:0] dim_a_c, img_addr_c;
    logic [FADDR_W-1:0] filt_addr_c;
    logic [OADDR_W-1:0] out_addr_c;
    logic [ACC_W-1:0]   bias_ext_c, sum_c;

    // length is stored for the host but never consumed; interrupt bit 19 is not exported
    logic unused_cfg;
    assign unused_cfg = ^{len_q, intr_q[IMM_W-1]};

    assign opc_c    = instruction[6:0];
    assign code_c   = instruction[11:7];
    assign imm_c    = instruction[31:12];
    assign is_ext_c = (opc_c == EXTEND_OPCODE);
    assign cfg_wr_c = is_ext_c && (code_c <= RD_ACCEL_INTERRUPT)
                      && ((state_q == IDLE) || (state_q == DONE));

    // K = 2*halfsize+1 and K-1 fall out of a simple shift
    assign k_c          = {half_q, 1'b1};
    assign k_last_c     = {half_q, 1'b0};
    assign stride_eff_c = (stride_q == '0) ? IMM_W'(1) : stride_q;
    assign degenerate_c = ({1'b0, dim_q} < k_c) || (depth_q == '0);
    assign last_tap_c   = (dx_q == k_last_c) && (dy_q == k_last_c)
                          && (c_q == depth_q - IMM_W'(1));

    // next window fits if its far edge stays inside the image; avoids a divider for out_dim
    assign xb_nx_c  = POS_W'(xb_q) + POS_W'(stride_eff_c);
    assign yb_nx_c  = POS_W'(yb_q) + POS_W'(stride_eff_c);
    assign x_fits_c = (xb_nx_c + POS_W'(k_c)) <= POS_W'(dim_q);
    assign y_fits_c = (yb_nx_c + POS_W'(k_c)) <= POS_W'(dim_q);

    assign prod_c     = $signed(mem_in[35:18]) * $signed(mem_in[17:0]);
    assign bias_ext_c = {{(ACC_W-DATA_W){bias_q[DATA_W-1]}}, bias_q[DATA_W-1:0]};

    // next-state, iteration and registered-output computation
    always_comb begin
        state_d    = state_q;
        dim_d      = dim_q;
        depth_d    = depth_q;
        img_off_d  = img_off_q;
        filt_off_d = filt_off_q;
        out_off_d  = out_off_q;
        half_d     = half_q;
        stride_d   = stride_q;
        len_d      = len_q;
        bias_d     = bias_q;
        intr_d     = intr_q;
        c_d        = c_q;
        dy_d       = dy_q;
        dx_d       = dx_q;
        xb_d       = xb_q;
        yb_d       = yb_q;
        out_idx_d  = out_idx_q;
        acc_d      = acc_q;
        mem_out_d  = '0;

        if (cfg_wr_c) begin
            case (code_c)
                RD_IMAGE_DIM:       dim_d      = imm_c;
                RD_IMAGE_DEPTH:     depth_d    = imm_c;
                RD_IMAGE_OFFSET:    img_off_d  = imm_c;
                RD_FILTER_OFFSET:   filt_off_d = imm_c;
                RD_OUTPUT_OFFSET:   out_off_d  = imm_c;
                RD_FILTER_HALFSIZE: half_d     = imm_c;
                RD_FILTER_STRIDE:   stride_d   = imm_c;
                RD_FILTER_LENGTH:   len_d      = imm_c;
                RD_FILTER_BIAS:     bias_d     = imm_c;
                RD_ACCEL_INTERRUPT: intr_d     = imm_c;
                default: ;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (is_ext_c && (code_c == RD_TRIGGER_ACCEL)) begin
                    if (degenerate_c) begin
                        state_d = DONE;
                    end else begin
                        state_d   = MAC;
                        c_d       = '0;
                        dy_d      = '0;
                        dx_d      = '0;
                        xb_d      = '0;
                        yb_d      = '0;
                        out_idx_d = '0;
                        acc_d     = '0;
                    end
                end
            end
            MAC: begin
                acc_d = acc_q + {{(ACC_W-PROD_W){prod_c[PROD_W-1]}}, prod_c};
                if (last_tap_c) begin
                    state_d = WRITE;
                end else if (dx_q != k_last_c) begin
                    dx_d = dx_q + KW'(1);
                end else begin
                    dx_d = '0;
                    if (dy_q != k_last_c) begin
                        dy_d = dy_q + KW'(1);
                    end else begin
                        dy_d = '0;
                        c_d  = c_q + IMM_W'(1);
                    end
                end
            end
            WRITE: begin
                acc_d     = '0;
                c_d       = '0;
                dy_d      = '0;
                dx_d      = '0;
                out_idx_d = out_idx_q + OADDR_W'(1);
                if (x_fits_c) begin
                    xb_d    = IADDR_W'(xb_nx_c);
                    state_d = MAC;
                end else if (y_fits_c) begin
                    xb_d    = '0;
                    yb_d    = IADDR_W'(yb_nx_c);
                    state_d = MAC;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cfg_wr_c) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // bus for the cycle being entered, built from next-state values
        dim_a_c     = IADDR_W'(dim_q);
        img_addr_c  = IADDR_W'(img_off_q) + IADDR_W'(c_d) * dim_a_c * dim_a_c
                      + (yb_d + IADDR_W'(dy_d)) * dim_a_c + xb_d + IADDR_W'(dx_d);
        filt_addr_c = FADDR_W'(filt_off_q) + FADDR_W'(dy_d) * FADDR_W'(k_c) + FADDR_W'(dx_d);
        out_addr_c  = OADDR_W'(out_off_q) + out_idx_d;
        sum_c       = acc_d + bias_ext_c;

        case (state_d)
            MAC: begin
                mem_out_d[106:86] = img_addr_c;
                mem_out_d[85:70]  = filt_addr_c;
            end
            WRITE: begin
                mem_out_d[69:54] = out_addr_c;
                mem_out_d[53:36] = DATA_W'(sum_c);
                mem_out_d[35]    = 1'b1;
            end
            default: ;
        endcase

        done_d     = (state_d == DONE);
        intr_out_d = (state_d == DONE) ? intr_d[INTR_W-1:0] : '0;
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst_ext) begin
        if (rst_ext) begin
            state_q    <= IDLE;
            dim_q      <= '0;
            depth_q    <= '0;
            img_off_q  <= '0;
            filt_off_q <= '0;
            out_off_q  <= '0;
            half_q     <= '0;
            stride_q   <= '0;
            len_q      <= '0;
            bias_q     <= '0;
            intr_q     <= '0;
            c_q        <= '0;
            dy_q       <= '0;
            dx_q       <= '0;
            xb_q       <= '0;
            yb_q       <= '0;
            out_idx_q  <= '0;
            acc_q      <= '0;
            mem_out_q  <= '0;
            done_q     <= 1'b0;
            intr_out_q <= '0;
        end else begin
            state_q    <= state_d;
            dim_q      <= dim_d;
            depth_q    <= depth_d;
            img_off_q  <= img_off_d;
            filt_off_q <= filt_off_d;
            out_off_q  <= out_off_d;
            half_q     <= half_d;
            stride_q   <= stride_d;
            len_q      <= len_d;
            bias_q     <= bias_d;
            intr_q     <= intr_d;
            c_q        <= c_d;
            dy_q       <= dy_d;
            dx_q       <= dx_d;
            xb_q       <= xb_d;
            yb_q       <= yb_d;
            out_idx_q  <= out_idx_d;
            acc_q      <= acc_d;
            mem_out_q  <= mem_out_d;
            done_q     <= done_d;
            intr_out_q <= intr_out_d;
        end
    end

    assign mem_out         = mem_out_q;
    assign accel_done      = done_q;
    assign accel_interrupt = intr_out_q;

endmodule

// File: tb/tb_accel.sv
// Directed testbench for accel with a behavioural memory attached to the bus.
module tb_accel;

    localparam int MEM_N = 256;
    localparam logic [6:0] EXT = 7'b0001011;

    logic         clk = 1'b0;
    logic         rst_ext;
    logic [31:0]  instruction;
    logic [35:0]  mem_in;
    logic [106:0] mem_out;
    logic         accel_done;
    logic [18:0]  accel_interrupt;

    logic [17:0] mem [MEM_N];
    logic [1:0]  mem_mode;
    int          wr_count;
    int          n_checks;
    int          n_fail;

    accel dut (
        .clk             (clk),
        .rst_ext         (rst_ext),
        .instruction     (instruction),
        .mem_in          (mem_in),
        .mem_out         (mem_out),
        .accel_done      (accel_done),
        .accel_interrupt (accel_interrupt)
    );

    always #5 clk = ~clk;

    // combinational read ports; out-of-range reads return zero
    always_comb begin
        mem_in = '0;
        if (mem_out[106:94] == 13'd0) mem_in[35:18] = mem[mem_out[93:86]];
        if (mem_out[85:78] == 8'd0)   mem_in[17:0]  = mem[mem_out[77:70]];
    end

    // memory loading (mode 1: standard image/filter, mode 2: signed case) and write port
    always @(posedge clk) begin
        if (mem_mode != 2'd0) begin
            for (int i = 0; i < MEM_N; i++) begin
                if (mem_mode == 2'd1)
                    mem[i] <= (i < 76) ? 18'(i) : ((i < 85) ? 18'(i - 76) : 18'd0);
                else
                    mem[i] <= (i == 0) ? 18'h3FFFF : ((i == 1) ? 18'd2 : 18'd0);
            end
            wr_count <= 0;
        end else if (mem_out[35]) begin
            if (mem_out[69:62] == 8'd0) mem[mem_out[61:54]] <= mem_out[53:36];
            wr_count <= wr_count + 1;
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] code, input logic [19:0] imm);
        return {imm, code, EXT};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] code, input logic [19:0] imm);
        instruction = mk(code, imm);
        tick();
        instruction = 32'h0;
    endtask

    task automatic do_reset();
        rst_ext = 1'b1;
        tick();
        tick();
        rst_ext = 1'b0;
        tick();
    endtask

    task automatic init_mem(input logic [1:0] mode);
        mem_mode = mode;
        tick();
        mem_mode = 2'd0;
    endtask

    task automatic cfg_std(input logic [19:0] stride, input logic [19:0] bias);
        issue(5'd0, 20'd5);
        issue(5'd1, 20'd3);
        issue(5'd2, 20'd0);
        issue(5'd3, 20'd76);
        issue(5'd4, 20'd86);
        issue(5'd5, 20'd1);
        issue(5'd6, stride);
        issue(5'd7, 20'd9);
        issue(5'd8, bias);
        issue(5'd9, 20'hF00BA);
    endtask

    // cycles after the trigger edge until accel_done is seen, -1 on timeout
    task automatic wait_done(input int budget, input int inject_at, output int cycles);
        int n;
        n = 0;
        cycles = -1;
        while (cycles < 0 && n < budget) begin
            n++;
            if (n == inject_at) instruction = mk(5'd0, 20'd7);
            tick();
            instruction = 32'h0;
            if (accel_done) cycles = n;
        end
    endtask

    task automatic test_reset();
        rst_ext = 1'b1;
        instruction = 32'h0;
        mem_mode = 2'd0;
        #2;
        n_checks++; if (mem_out !== 107'd0) begin n_fail++; $display("FAIL reset_mem_out: got %h expected 0", mem_out); end
        n_checks++; if (accel_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", accel_done); end
        n_checks++; if (accel_interrupt !== 19'd0) begin n_fail++; $display("FAIL reset_intr: got %h expected 0", accel_interrupt); end
        tick();
        rst_ext = 1'b0;
        tick();
    endtask

    task automatic test_degenerate();
        do_reset();
        init_mem(2'd1);
        issue(5'd0, 20'd2);
        issue(5'd5, 20'd1);
        issue(5'd1, 20'd3);
        issue(5'd9, 20'h12345);
        instruction = {20'h55555, 5'd9, 7'b0110011};
        tick();
        instruction = 32'h0;
        issue(5'd10, 20'd0);
        n_checks++; if (accel_done !== 1'b1) begin n_fail++; $display("FAIL degen_done: got %b expected 1", accel_done); end
        n_checks++; if (accel_interrupt !== 19'h12345) begin n_fail++; $display("FAIL degen_intr: got %h expected 12345", accel_interrupt); end
        tick();
        tick();
        n_checks++; if (mem_out !== 107'd0) begin n_fail++; $display("FAIL degen_bus: got %h expected 0", mem_out); end
        issue(5'd0, 20'd5);
        n_checks++; if (accel_done !== 1'b0) begin n_fail++; $display("FAIL cfg_in_done_idle: got %b expected 0", accel_done); end
        n_checks++; if (accel_interrupt !== 19'd0) begin n_fail++; $display("FAIL cfg_in_done_intr: got %h expected 0", accel_interrupt); end
        issue(5'd1, 20'd0);
        issue(5'd10, 20'd0);
        n_checks++; if (accel_done !== 1'b1) begin n_fail++; $display("FAIL depth0_done: got %b expected 1", accel_done); end
        n_checks++; if (wr_count !== 0) begin n_fail++; $display("FAIL degen_writes: got %0d expected 0", wr_count); end
    endtask

    task automatic test_signed();
        int cyc;
        do_reset();
        init_mem(2'd2);
        issue(5'd0, 20'd1);
        issue(5'd1, 20'd1);
        issue(5'd2, 20'd0);
        issue(5'd3, 20'd1);
        issue(5'd4, 20'd86);
        issue(5'd5, 20'd0);
        issue(5'd6, 20'd0);
        issue(5'd8, 20'hFFFFD);
        issue(5'd10, 20'd0);
        wait_done(20, 0, cyc);
        n_checks++; if (cyc !== 2) begin n_fail++; $display("FAIL signed_cycles: got %0d expected 2", cyc); end
        n_checks++; if (mem[86] !== 18'h3FFFB) begin n_fail++; $display("FAIL signed_data: got %h expected 3fffb", mem[86]); end
        n_checks++; if (wr_count !== 1) begin n_fail++; $display("FAIL signed_writes: got %0d expected 1", wr_count); end
        n_checks++; if (accel_interrupt !== 19'd0) begin n_fail++; $display("FAIL signed_intr: got %h expected 0", accel_interrupt); end
    endtask

    task automatic test_basic(input int inject_at, input string tag);
        int cyc;
        int unsigned exp_v [9];
        exp_v = '{3636, 3744, 3852, 4176, 4284, 4392, 4716, 4824, 4932};
        do_reset();
        init_mem(2'd1);
        cfg_std(20'd1, 20'd0);
        issue(5'd10, 20'd0);
        wait_done(400, inject_at, cyc);
        n_checks++; if (cyc !== 252) begin n_fail++; $display("FAIL %s_cycles: got %0d expected 252", tag, cyc); end
        for (int i = 0; i < 9; i++) begin
            n_checks++;
            if (mem[86 + i] !== 18'(exp_v[i])) begin
                n_fail++; $display("FAIL %s_out%0d: got %0d expected %0d", tag, i, mem[86 + i], exp_v[i]);
            end
        end
        n_checks++; if (wr_count !== 9) begin n_fail++; $display("FAIL %s_writes: got %0d expected 9", tag, wr_count); end
        n_checks++; if (accel_interrupt !== 19'h700BA) begin n_fail++; $display("FAIL %s_intr: got %h expected 700ba", tag, accel_interrupt); end
        n_checks++; if (mem_out !== 107'd0) begin n_fail++; $display("FAIL %s_bus_done: got %h expected 0", tag, mem_out); end
    endtask

    task automatic test_held_trigger();
        int snap;
        snap = wr_count;
        instruction = mk(5'd10, 20'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            n_checks++;
            if (accel_done !== 1'b1) begin n_fail++; $display("FAIL held_done_c%0d: got %b expected 1", i, accel_done); end
        end
        instruction = 32'h0;
        n_checks++; if (wr_count !== snap) begin n_fail++; $display("FAIL held_writes: got %0d expected %0d", wr_count, snap); end
    endtask

    task automatic test_stride();
        int cyc;
        int unsigned exp_v [4];
        exp_v = '{3646, 3862, 4726, 4942};
        do_reset();
        init_mem(2'd1);
        cfg_std(20'd2, 20'd10);
        issue(5'd10, 20'd0);
        wait_done(400, 0, cyc);
        n_checks++; if (cyc !== 112) begin n_fail++; $display("FAIL stride_cycles: got %0d expected 112", cyc); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[86 + i] !== 18'(exp_v[i])) begin
                n_fail++; $display("FAIL stride_out%0d: got %0d expected %0d", i, mem[86 + i], exp_v[i]);
            end
        end
        n_checks++; if (wr_count !== 4) begin n_fail++; $display("FAIL stride_writes: got %0d expected 4", wr_count); end
        n_checks++; if (mem[90] !== 18'd0) begin n_fail++; $display("FAIL stride_extra: got %0d expected 0", mem[90]); end
    endtask

    task automatic test_reset_mid();
        logic [106:0] exp_bus;
        exp_bus = {21'd26, 16'd77, 70'd0};
        do_reset();
        init_mem(2'd1);
        cfg_std(20'd1, 20'd0);
        issue(5'd10, 20'd0);
        for (int i = 0; i < 10; i++) tick();
        n_checks++; if (mem_out !== exp_bus) begin n_fail++; $display("FAIL mid_tap10_bus: got %h expected %h", mem_out, exp_bus); end
        #3 rst_ext = 1'b1;
        #1;
        n_checks++; if (mem_out !== 107'd0) begin n_fail++; $display("FAIL mid_reset_bus: got %h expected 0", mem_out); end
        n_checks++; if (accel_done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done: got %b expected 0", accel_done); end
        tick();
        rst_ext = 1'b0;
        for (int i = 0; i < 60; i++) tick();
        n_checks++; if (wr_count !== 0) begin n_fail++; $display("FAIL mid_writes: got %0d expected 0", wr_count); end
        n_checks++; if (accel_done !== 1'b0) begin n_fail++; $display("FAIL mid_idle_done: got %b expected 0", accel_done); end
        n_checks++; if (mem_out !== 107'd0) begin n_fail++; $display("FAIL mid_idle_bus: got %h expected 0", mem_out); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_degenerate();
        test_signed();
        test_basic(0, "basic");
        test_held_trigger();
        test_stride();
        test_basic(5, "busy_cfg");
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/accel.md
ACCEL -- requirements
Module: accel

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports named as below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_ext  input  1  asynchronous active-high reset.
REQ-004 instruction  input  32  host instruction: [6:0] opcode, [11:7] register code, [31:12] 20-bit immediate.
REQ-005 mem_in  input  36  combinational read data: [35:18] image word at mem_out[106:86], [17:0] filter word at mem_out[85:70].
REQ-006 mem_out  output  107  memory bus: [106:86] image read addr, [85:70] filter read addr, [69:54] output write addr, [53:36] write data, [35] write enable, [34:0] constant 0.
REQ-007 accel_done  output  1  high while in DONE.
REQ-008 accel_interrupt  output  19  stored interrupt vector [18:0] while in DONE, else 0.
REQ-009 Constants: EXTEND_OPCODE=7'b0001011; register codes RD_IMAGE_DIM=0, RD_IMAGE_DEPTH=1, RD_IMAGE_OFFSET=2, RD_FILTER_OFFSET=3, RD_OUTPUT_OFFSET=4, RD_FILTER_HALFSIZE=5, RD_FILTER_STRIDE=6, RD_FILTER_LENGTH=7, RD_FILTER_BIAS=8, RD_ACCEL_INTERRUPT=9, RD_TRIGGER_ACCEL=10; codes 11-31 ignored.

Function
REQ-010 Instructions with opcode != EXTEND_OPCODE SHALL be ignored.
REQ-011 Config codes 0-9 SHALL latch the 20-bit immediate into the named register at the clock edge, in IDLE or DONE only; ignored while busy.
REQ-012 A config write in DONE SHALL also move the FSM to IDLE.
REQ-013 RD_TRIGGER_ACCEL SHALL start computation only in IDLE; ignored in MAC, WRITE, DONE (a held trigger never restarts).
REQ-014 FSM states: IDLE, MAC, WRITE, DONE; IDLE->MAC on trigger; MAC->WRITE after last tap; WRITE->MAC for next output or ->DONE after last output.
REQ-015 Geometry: K=2*halfsize+1; stride 0 treated as 1; out_dim=(dim-K)/stride+1 (valid convolution, no padding).
REQ-016 If dim<K or depth=0, trigger SHALL go directly to DONE with no writes.
REQ-017 Image layout: channel-major, row-major; tap address = image_offset + c*dim*dim + (oy*stride+dy)*dim + (ox*stride+dx), 21 bits.
REQ-018 Filter: single KxK 2D kernel shared by all channels; address = filter_offset + dy*K + dx, 16 bits.
REQ-019 filter_length SHALL be stored only; computation uses K*K taps; mismatch not checked.
REQ-020 MAC: one tap per cycle, loop order c outer, dy, dx inner; acc += signed(mem_in[35:18]) * signed(mem_in[17:0]) at each MAC edge; acc at least 48 bits, cleared before each output.
REQ-021 WRITE: exactly one cycle, write enable=1, addr = output_offset + oy*out_dim + ox, data = low 18 bits of (acc + sign-extended bias[17:0]).
REQ-022 Outputs SHALL be produced in raster order (oy outer, ox inner); cycles per output = depth*K*K + 1.
REQ-023 mem_out write enable SHALL be 0 outside WRITE; all mem_out bits SHALL be 0 in IDLE and DONE.
REQ-024 Overflow wraps (truncation), no saturation.

Reset
REQ-025 rst_ext SHALL immediately force IDLE, clear all config registers and accumulator, and drive mem_out, accel_done, accel_interrupt to 0.
REQ-026 Reset mid-computation SHALL abort with no further writes; no computation until a new trigger after release.

Verification
REQ-027 Memory[i]=i (i<76), memory[76..84]=0..8; dim=5, depth=3, img_off=0, filt_off=76, out_off=86, halfsize=1, stride=1, length=9, bias=0, interrupt=0xF00BA, trigger -> memory[86..94]=3636,3744,3852,4176,4284,4392,4716,4824,4932; accel_done high 252 cycles after trigger; accel_interrupt=0x700BA.
REQ-028 Same setup, stride=2, bias=10 -> memory[86..89]=3646,3862,4726,4942; no other writes.
REQ-029 Trigger instruction held after DONE -> accel_done stays high, no further writes.
REQ-030 Reset asserted mid-MAC -> outputs 0 at once; no writes after reset; idle until new trigger.
REQ-031 dim=2, halfsize=1, trigger -> DONE next cycle, zero writes.
REQ-032 Config write while busy (e.g. dim=7 during MAC) -> ignored; results identical to REQ-027.
